controlador_barramento: RTL and testbench

- Shared-bus and main-memory controller that sits directly downstream of the N snooping processors.
- Each cycle it arbitrates one processor transaction and broadcasts the bus message (invalidar/readMiss/writeMiss) to all caches.
- It applies the requester's eviction write-back, collects snoop write-backs from other caches, and serves the memory read.
- It returns the read data to the requester with a one-cycle done pulse.

---
 rtl/controlador_barramento_pkg.sv | 26 ++
 rtl/controlador_barramento_arbitro_rr.sv | 29 ++
 rtl/controlador_barramento.sv | 233 +++++++++++++++++++++++
 tb/tb_controlador_barramento.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/controlador_barramento_pkg.sv
// rtl/controlador_barramento_pkg.sv - shared message, FSM and MSI encodings for the bus controller
package ctrl_barramento_pkg;

    typedef enum logic [1:0] {
        INVALIDAR    = 2'b00,
        READ_MISS    = 2'b01,
        WRITE_MISS   = 2'b10,
        SEM_MENSAGEM = 2'b11
    } msg_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_WB    = 3'd2,
        ST_SNOOP = 3'd3,
        ST_READ  = 3'd4,
        ST_DONE  = 3'd5
    } estado_t;

    typedef enum logic [1:0] {
        INVALIDO      = 2'b00,
        MODIFICADO    = 2'b01,
        COMPARTILHADO = 2'b10
    } msi_t;

endpackage

// File: rtl/controlador_barramento_arbitro_rr.sv
// rtl/controlador_barramento_arbitro_rr.sv - combinational round-robin pick starting after rr_ptr
module arbitro_rr #(
    parameter int N_PROC = 3
) (
    input  logic [N_PROC-1:0] req,
    input  logic [1:0]        rr_ptr,
    output logic [1:0]        winner,
    output logic              any_req
);

    // Two passes: indices above the pointer first, then wrap to the ones at or below it.
    always_comb begin
        winner  = 2'd0;
        any_req = 1'b0;
        for (int j = 0; j < N_PROC; j++) begin
            if (!any_req && req[j] && (j > int'(rr_ptr))) begin
                any_req = 1'b1;
                winner  = 2'(j);
            end
        end
        for (int j = 0; j < N_PROC; j++) begin
            if (!any_req && req[j] && (j <= int'(rr_ptr))) begin
                any_req = 1'b1;
                winner  = 2'(j);
            end
        end
    end

endmodule

// File: rtl/controlador_barramento.sv
// rtl/controlador_barramento.sv - shared-bus arbiter, snoop collector and main-memory controller
module controlador_barramento
    import ctrl_barramento_pkg::*;
#(
    parameter int N_PROC    = 3,
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 3,
    parameter int SNOOP_CYC = 2,
    parameter int MEM_LAT   = 2
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [N_PROC-1:0]        req,
    input  logic [2*N_PROC-1:0]      msg_in,
    input  logic [N_PROC-1:0]        wb_valid,
    input  logic [ADDR_W*N_PROC-1:0] wb_addr,
    input  logic [DATA_W*N_PROC-1:0] wb_data,
    input  logic [N_PROC-1:0]        rd_en,
    input  logic [ADDR_W*N_PROC-1:0] addr_in,
    input  logic [N_PROC-1:0]        snoop_wb,
    input  logic [DATA_W*N_PROC-1:0] snoop_data,
    output logic [N_PROC-1:0]        gnt,
    output logic                     bus_valid,
    output logic [1:0]               bus_msg,
    output logic [1:0]               bus_src,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [N_PROC-1:0]        done,
    output logic [DATA_W-1:0]        rd_data
);

    localparam int MEM_D = 2**ADDR_W;

    estado_t           state_q, state_d;
    logic [1:0]        win_q, win_d;
    logic [1:0]        msg_q, msg_d;
    logic              wbv_q, wbv_d;
    logic [ADDR_W-1:0] wba_q, wba_d;
    logic [DATA_W-1:0] wbd_q, wbd_d;
    logic              rden_q, rden_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              fwd_q, fwd_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] mem_q [MEM_D];
    logic [DATA_W-1:0] mem_d [MEM_D];

    logic [1:0]        arb_win;
    logic              arb_any;
    logic [1:0]        sel_msg;
    logic              sel_wbv;
    logic [ADDR_W-1:0] sel_wba;
    logic [DATA_W-1:0] sel_wbd;
    logic              sel_rden;
    logic [ADDR_W-1:0] sel_addr;
    logic              snp_hit;
    logic [DATA_W-1:0] snp_data;
    logic              snoop_last;
    logic              read_last;
    logic              fwd_now;

    arbitro_rr #(
        .N_PROC (N_PROC)
    ) u_arbitro (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .winner  (arb_win),
        .any_req (arb_any)
    );

    always_comb begin
        sel_msg  = SEM_MENSAGEM;
        sel_wbv  = 1'b0;
        sel_wba  = '0;
        sel_wbd  = '0;
        sel_rden = 1'b0;
        sel_addr = '0;
        for (int j = 0; j < N_PROC; j++) begin
            if (arb_win == 2'(j)) begin
                sel_msg  = msg_in[2*j +: 2];
                sel_wbv  = wb_valid[j];
                sel_wba  = wb_addr[ADDR_W*j +: ADDR_W];
                sel_wbd  = wb_data[DATA_W*j +: DATA_W];
                sel_rden = rd_en[j];
                sel_addr = addr_in[ADDR_W*j +: ADDR_W];
            end
        end
    end

    // Descending scan so the lowest flushing index overrides; the winner's own flush is ignored.
    always_comb begin
        snp_hit  = 1'b0;
        snp_data = '0;
        for (int j = N_PROC-1; j >= 0; j--) begin
            if (snoop_wb[j] && (win_q != 2'(j))) begin
                snp_hit  = 1'b1;
                snp_data = snoop_data[DATA_W*j +: DATA_W];
            end
        end
    end

    assign snoop_last = (cnt_q == 4'(SNOOP_CYC-1));
    assign read_last  = (cnt_q == 4'(MEM_LAT-1));
    assign fwd_now    = fwd_q | snp_hit;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            win_q      <= 2'd0;
            msg_q      <= SEM_MENSAGEM;
            wbv_q      <= 1'b0;
            wba_q      <= '0;
            wbd_q      <= '0;
            rden_q     <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= 4'd0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            rr_ptr_q   <= 2'(N_PROC-1);
            rd_data_q  <= '0;
            for (int i = 0; i < MEM_D; i++) begin
                mem_q[i] <= DATA_W'(i);
            end
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            msg_q      <= msg_d;
            wbv_q      <= wbv_d;
            wba_q      <= wba_d;
            wbd_q      <= wbd_d;
            rden_q     <= rden_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_data_q  <= rd_data_d;
            for (int i = 0; i < MEM_D; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (arb_any) state_d = ST_GRANT;
            ST_GRANT: state_d = wbv_q ? ST_WB : ST_SNOOP;
            ST_WB:    state_d = ST_SNOOP;
            ST_SNOOP: if (snoop_last) state_d = (rden_q && !fwd_now) ? ST_READ : ST_DONE;
            ST_READ:  if (read_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        win_d      = win_q;
        msg_d      = msg_q;
        wbv_d      = wbv_q;
        wba_d      = wba_q;
        wbd_d      = wbd_q;
        rden_d     = rden_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        fwd_d      = fwd_q;
        fwd_data_d = fwd_data_q;
        rr_ptr_d   = rr_ptr_q;
        rd_data_d  = rd_data_q;
        for (int i = 0; i < MEM_D; i++) begin
            mem_d[i] = mem_q[i];
        end
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                fwd_d = 1'b0;
                if (arb_any) begin
                    win_d  = arb_win;
                    msg_d  = sel_msg;
                    wbv_d  = sel_wbv;
                    wba_d  = sel_wba;
                    wbd_d  = sel_wbd;
                    rden_d = sel_rden;
                    addr_d = sel_addr;
                end
            end
            ST_GRANT: cnt_d = 4'd0;
            ST_WB: begin
                cnt_d        = 4'd0;
                mem_d[wba_q] = wbd_q;
            end
            ST_SNOOP: begin
                if (snp_hit) begin
                    mem_d[addr_q] = snp_data;
                    fwd_d         = 1'b1;
                    fwd_data_d    = snp_data;
                end
                if (snoop_last) begin
                    cnt_d = 4'd0;
                    if (rden_q && fwd_now) rd_data_d = fwd_data_d;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_READ: begin
                if (read_last) begin
                    cnt_d     = 4'd0;
                    rd_data_d = mem_q[addr_q];
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: rr_ptr_d = win_q;
            default: cnt_d = 4'd0;
        endcase
    end

    always_comb begin
        gnt       = '0;
        done      = '0;
        bus_valid = (state_q == ST_GRANT);
        bus_msg   = (state_q == ST_GRANT) ? msg_q : SEM_MENSAGEM;
        bus_src   = (state_q != ST_IDLE) ? win_q : 2'd0;
        bus_addr  = (state_q != ST_IDLE) ? addr_q : '0;
        rd_data   = rd_data_q;
        for (int j = 0; j < N_PROC; j++) begin
            gnt[j]  = (state_q != ST_IDLE) && (win_q == 2'(j));
            done[j] = (state_q == ST_DONE) && (win_q == 2'(j));
        end
    end

endmodule

// File: tb/tb_controlador_barramento.sv
// tb/tb_controlador_barramento.sv - directed self-checking bench for controlador_barramento
module tb_controlador_barramento;

    logic       clock = 1'b0;
    logic       resetn;
    logic [2:0] req;
    logic [5:0] msg_in;
    logic [2:0] wb_valid;
    logic [8:0] wb_addr;
    logic [8:0] wb_data;
    logic [2:0] rd_en;
    logic [8:0] addr_in;
    logic [2:0] snoop_wb;
    logic [8:0] snoop_data;
    logic [2:0] gnt;
    logic       bus_valid;
    logic [1:0] bus_msg;
    logic [1:0] bus_src;
    logic [2:0] bus_addr;
    logic [2:0] done;
    logic [2:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;

    controlador_barramento dut (
        .clock      (clock),
        .resetn     (resetn),
        .req        (req),
        .msg_in     (msg_in),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rd_en      (rd_en),
        .addr_in    (addr_in),
        .snoop_wb   (snoop_wb),
        .snoop_data (snoop_data),
        .gnt        (gnt),
        .bus_valid  (bus_valid),
        .bus_msg    (bus_msg),
        .bus_src    (bus_src),
        .bus_addr   (bus_addr),
        .done       (done),
        .rd_data    (rd_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req        = '0;
        msg_in     = '1;
        wb_valid   = '0;
        wb_addr    = '0;
        wb_data    = '0;
        rd_en      = '0;
        addr_in    = '0;
        snoop_wb   = '0;
        snoop_data = '0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},       32'(gnt),       32'h0);
        check({tag, "_bus_valid"}, 32'(bus_valid), 32'h0);
        check({tag, "_bus_msg"},   32'(bus_msg),   32'h3);
        check({tag, "_bus_src"},   32'(bus_src),   32'h0);
        check({tag, "_bus_addr"},  32'(bus_addr),  32'h0);
        check({tag, "_done"},      32'(done),      32'h0);
        check({tag, "_rd_data"},   32'(rd_data),   32'h0);
    endtask

    // lat = edges after the sampling edge t0 until done is visible; snp_idx < 0 means no flush.
    task automatic run_txn(input string tag, input int p, input logic [1:0] msg,
                           input logic [2:0] addr, input logic rden, input logic wbv,
                           input logic [2:0] wba, input logic [2:0] wbd,
                           input int snp_idx, input logic [2:0] snp_val,
                           input int lat, input logic [2:0] exp_rd);
        logic [2:0] oh;
        oh = 3'(1 << p);
        clear_inputs();
        req[p]            = 1'b1;
        msg_in[2*p +: 2]  = msg;
        addr_in[3*p +: 3] = addr;
        rd_en[p]          = rden;
        wb_valid[p]       = wbv;
        wb_addr[3*p +: 3] = wba;
        wb_data[3*p +: 3] = wbd;
        tick();
        check({tag, "_bus_valid"}, 32'(bus_valid), 32'h1);
        check({tag, "_bus_msg"},   32'(bus_msg),   32'(msg));
        check({tag, "_bus_src"},   32'(bus_src),   32'(p));
        check({tag, "_gnt"},       32'(gnt),       32'(oh));
        check({tag, "_bus_addr"},  32'(bus_addr),  32'(addr));
        for (int c = 2; c <= lat + 1; c++) begin
            tick();
            if (c == 2) begin
                check({tag, "_bus_valid_drop"}, 32'(bus_valid), 32'h0);
                check({tag, "_bus_msg_idle"},   32'(bus_msg),   32'h3);
                if (snp_idx >= 0) begin
                    snoop_wb[snp_idx]            = 1'b1;
                    snoop_data[3*snp_idx +: 3]   = snp_val;
                end
            end else if (c == 3) begin
                snoop_wb   = '0;
                snoop_data = '0;
            end
            if (c < lat + 1) begin
                check($sformatf("%s_no_done_t%0d", tag, c - 1), 32'(done), 32'h0);
            end else begin
                check({tag, "_done"},     32'(done),     32'(oh));
                check({tag, "_rd_data"},  32'(rd_data),  32'(exp_rd));
                check({tag, "_gnt_hold"}, 32'(gnt),      32'(oh));
                check({tag, "_addr_hold"},32'(bus_addr), 32'(addr));
            end
        end
        req = '0;
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'h0);
        check({tag, "_gnt_clear"},  32'(gnt),  32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        int         exp_w;
        logic [2:0] seen_done;

        clear_inputs();
        apply_reset();
        check_reset_outputs("reset");

        run_txn("p1_read5", 1, 2'b01, 3'd5, 1'b1, 1'b0, 3'd0, 3'd0, -1, 3'd0, 5, 3'd5);
        run_txn("p0_read2_wb6", 0, 2'b01, 3'd2, 1'b1, 1'b1, 3'd6, 3'd3, -1, 3'd0, 6, 3'd2);
        run_txn("p2_read6", 2, 2'b01, 3'd6, 1'b1, 1'b0, 3'd0, 3'd0, -1, 3'd0, 5, 3'd3);
        run_txn("p0_inval1", 0, 2'b00, 3'd1, 1'b0, 1'b0, 3'd0, 3'd0, -1, 3'd0, 3, 3'd3);
        run_txn("p2_read3_snoop", 2, 2'b01, 3'd3, 1'b1, 1'b0, 3'd0, 3'd0, 1, 3'd0, 3, 3'd0);
        run_txn("p0_read3_after", 0, 2'b01, 3'd3, 1'b1, 1'b0, 3'd0, 3'd0, -1, 3'd0, 5, 3'd0);
        run_txn("p0_read1_selfsnoop", 0, 2'b01, 3'd1, 1'b1, 1'b0, 3'd0, 3'd0, 0, 3'd7, 5, 3'd1);

        clear_inputs();
        req[1]          = 1'b1;
        msg_in[3:2]     = 2'b01;
        addr_in[5:3]    = 3'd5;
        rd_en[1]        = 1'b1;
        tick();
        tick();
        resetn = 1'b0;
        tick();
        check_reset_outputs("midreset");
        resetn = 1'b1;
        req    = '0;
        seen_done = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_done |= done;
        end
        check("midreset_no_done", 32'(seen_done), 32'h0);
        run_txn("mem3_restored", 1, 2'b01, 3'd3, 1'b1, 1'b0, 3'd0, 3'd0, -1, 3'd0, 5, 3'd3);
        run_txn("mem6_restored", 2, 2'b01, 3'd6, 1'b1, 1'b0, 3'd0, 3'd0, -1, 3'd0, 5, 3'd6);

        clear_inputs();
        req     = 3'b111;
        msg_in  = 6'b10_10_10;
        addr_in = {3'd6, 3'd4, 3'd2};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            exp_w = k % 3;
            cnt   = 0;
            while (!bus_valid && cnt < 10) begin
                tick();
                cnt++;
            end
            check($sformatf("rr%0d_grant_seen", k), 32'(bus_valid), 32'h1);
            check($sformatf("rr%0d_bus_src", k),    32'(bus_src),   32'(exp_w));
            check($sformatf("rr%0d_gnt", k),        32'(gnt),       32'(1 << exp_w));
            check($sformatf("rr%0d_bus_msg", k),    32'(bus_msg),   32'h2);
            cnt = 0;
            while (done == 3'b000 && cnt < 10) begin
                tick();
                cnt++;
            end
            check($sformatf("rr%0d_done", k),    32'(done),    32'(1 << exp_w));
            check($sformatf("rr%0d_rd_data", k), 32'(rd_data), 32'h0);
            tick();
            check($sformatf("rr%0d_done_pulse", k), 32'(done), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
